// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared definitions for the bit-serial add/subtract datapath.
//   state_t        - FSM state encoding (IDLE / ADD / DONE)
//   DEFAULT_WIDTH  - default operand/result width
//   cnt_width()    - bit-counter width needed to count 0..w
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_add_full_adder_bit.sv
// full_adder_bit: single-bit combinational full adder.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out (majority of a, b, cin)
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_core.sv
// serial_add_core: bit-serial adder/subtractor fed LSB-first by two upstream
// operand shift registers; deserialises the sum into a parallel result.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin an operation (honoured only in IDLE)
//   a_bit, b_bit : current LSBs of operand A / B
//   sub          : 1 = A-B, 0 = A+B, sampled with start
//                  (port exists only when SERIAL_ADD_SUB_EN is defined)
//   shift_en     : advance enable for both upstream shift registers
//   busy         : high in ADD and DONE
//   done         : one-cycle pulse, result valid
//   sum, cout    : parallel result and final carry (subtract: 1 = no borrow)
// Build option: define SERIAL_ADD_SUB_EN to enable subtraction.
module serial_add_core
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             a_bit,
   input  logic             b_bit,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic            carry_q;
   logic            op_q;
   logic            op_in;
   logic            b_eff;
   logic            s_bit;
   logic            c_next;
   logic            last_bit;

`ifdef SERIAL_ADD_SUB_EN
   assign op_in = sub;
`else
   assign op_in = 1'b0;
`endif

   // Subtraction is A + ~B + 1: invert B here, carry register preloaded with 1.
   assign b_eff    = b_bit ^ op_q;
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   full_adder_bit u_fa (
      .a    (a_bit),
      .b    (b_eff),
      .cin  (carry_q),
      .s    (s_bit),
      .cout (c_next)
   );

   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = ADD;
         end
         ADD: begin
            shift_en = 1'b1;
            busy     = 1'b1;
            if (last_bit) state_d = DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         op_q    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  carry_q <= op_in;
                  op_q    <= op_in;
                  cnt_q   <= '0;
               end
            end
            ADD: begin
               carry_q <= c_next;
               sum     <= {s_bit, sum[WIDTH-1:1]};
               cnt_q   <= cnt_q + CW'(1);
               // cout is captured only on the edge that enters DONE
               if (last_bit) cout <= c_next;
            end
            default: ;
         endcase
      end
   end

endmodule
